// File: rtl/l0_ctrl_pkg.sv
// Shared L0 sizing defaults and the tile sequencer state encoding.
package l0_ctrl_pkg;

   localparam int L0_ROW   = 8;
   localparam int L0_DEPTH = 64;
   localparam int LEN_W    = 7;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LOAD_TAIL,
      DRAIN,
      FLUSH,
      DONE
   } l0_state_e;

endpackage

// File: rtl/l0_ctrl.sv
// Tile sequencer: streams len vectors from activation SRAM into the L0 row FIFOs,
// drains them through the PE stagger chain, then flushes ROW-1 cycles before done.
module l0_ctrl
   import l0_ctrl_pkg::*;
#(
   parameter int ROW    = L0_ROW,
   parameter int DEPTH  = L0_DEPTH,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              l0_ready,
   output logic              sram_cen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              l0_wr,
   output logic              l0_rd,
   output logic              busy,
   output logic              done
);

   localparam int               CNT_W      = $clog2(DEPTH + ROW + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((ROW > 1) ? ROW - 2 : 0);
   localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(DEPTH);

   l0_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              l0_wr_q;

   logic issue;
   logic cnt_last;

   // l0_ready is the L0 not-full flag, itself a flop in L0, so gating the
   // chip enable with it keeps the issue decision in the same cycle.
   assign issue    = (state_q == LOAD) && l0_ready;
   assign cnt_last = ((cnt_q + CNT_ONE) == CNT_W'(len_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         len_q   <= '0;
         l0_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         len_q   <= len_d;
         l0_wr_q <= issue;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      len_d   = len_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
                  base_d  = base_addr;
                  len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                  cnt_d   = '0;
               end
            end
         end
         LOAD: begin
            if (issue) begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_last) begin
                  state_d = LOAD_TAIL;
               end
            end
         end
         LOAD_TAIL: begin
            cnt_d   = '0;
            state_d = DRAIN;
         end
         DRAIN: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = (ROW > 1) ? FLUSH : DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      sram_cen  = ~issue;
      sram_addr = base_q + ADDR_W'(cnt_q);
      l0_wr     = l0_wr_q;
      l0_rd     = (state_q == DRAIN);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

endmodule

// File: tb/tb_l0_ctrl.sv
// Scoreboarded bench for l0_ctrl: expected SRAM reads, L0 writes, drains and done pulses.
module tb_l0_ctrl;

   localparam int ROW    = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 11;

   localparam int K_RD = 0;
   localparam int K_WR = 1;
   localparam int K_DR = 2;
   localparam int K_DN = 3;

   typedef struct {
      int                cyc;
      int                kind;
      logic [ADDR_W-1:0] addr;
   } ev_t;

   ev_t exp_q[$];

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [6:0]        len;
   logic              l0_ready;
   logic              sram_cen;
   logic [ADDR_W-1:0] sram_addr;
   logic              l0_wr;
   logic              l0_rd;
   logic              busy;
   logic              done;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   l0_ctrl #(.ROW(ROW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .l0_ready  (l0_ready),
      .sram_cen  (sram_cen),
      .sram_addr (sram_addr),
      .l0_wr     (l0_wr),
      .l0_rd     (l0_rd),
      .busy      (busy),
      .done      (done)
   );

   function automatic string kname(input int k);
      case (k)
         K_RD:    return "sram_rd";
         K_WR:    return "l0_wr";
         K_DR:    return "l0_rd";
         default: return "done";
      endcase
   endfunction

   task automatic push_ev(input int c, input int k, input logic [ADDR_W-1:0] a);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.addr = a;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_ev(input int k, input logic [ADDR_W-1:0] a);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected %s: cycle %0d addr %h, expected no activity", kname(k), cyc, a);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || (k == K_RD && e.addr !== a)) begin
            errors++;
            $display("FAIL event: got %s cycle %0d addr %h, expected %s cycle %0d addr %h",
                     kname(k), cyc, a, kname(e.kind), e.cyc, e.addr);
         end
      end
   endtask

   // Monitor: every visible output event in a cycle, in a fixed order.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (sram_cen !== 1'b1) check_ev(K_RD, sram_addr);
         if (l0_wr !== 1'b0)    check_ev(K_WR, '0);
         if (l0_rd !== 1'b0)    check_ev(K_DR, '0);
         if (done !== 1'b0)     check_ev(K_DN, '0);
         if (l0_wr !== 1'b0 || l0_rd !== 1'b0) begin
            checks++;
            if (l0_wr === 1'b1 && l0_rd === 1'b1) begin
               errors++;
               $display("FAIL wr_rd_overlap: l0_wr=%b l0_rd=%b, expected not both high (cycle %0d)",
                        l0_wr, l0_rd, cyc);
            end
         end
      end
   end

   // Expected events of one tile whose start is sampled in absolute cycle c0.
   // l0_ready is low in relative cycles [s0, s0+sl).
   task automatic push_tile(input int c0, input logic [ADDR_W-1:0] base, input int len_in,
                            input int s0, input int sl, output int dn);
      int L;
      int c;
      int ri;
      int wi;
      int clast;
      int iss[$];
      L = (len_in > DEPTH) ? DEPTH : len_in;
      if (L == 0) begin
         push_ev(c0 + 1, K_DN, '0);
         dn = 1;
         return;
      end
      c = 1;
      while (iss.size() < L) begin
         if (!(c >= s0 && c < s0 + sl)) iss.push_back(c);
         c++;
      end
      clast = iss[L-1];
      dn    = clast + L + ROW + 1;
      ri    = 0;
      wi    = 0;
      for (int k = 1; k <= dn; k++) begin
         if (ri < L && iss[ri] == k) begin
            push_ev(c0 + k, K_RD, base + ADDR_W'(ri));
            ri++;
         end
         if (wi < L && iss[wi] + 1 == k) begin
            push_ev(c0 + k, K_WR, '0);
            wi++;
         end
         if (k >= clast + 2 && k <= clast + 1 + L) push_ev(c0 + k, K_DR, '0);
         if (k == dn) push_ev(c0 + k, K_DN, '0);
      end
   endtask

   // Called just after a rising edge; that cycle is the tile's cycle 0.
   // With b2b set, start stays high through DONE and a second tile from base2 follows.
   task automatic run_tile(input logic [ADDR_W-1:0] base, input int len_in, input int s0,
                           input int sl, input bit b2b, input logic [ADDR_W-1:0] base2);
      int c0;
      int dn;
      int dn2;
      c0 = cyc;
      push_tile(c0, base, len_in, s0, sl, dn);
      if (b2b) push_tile(c0 + dn + 1, base2, len_in, 0, 0, dn2);
      start     = 1'b1;
      base_addr = base;
      len       = 7'(len_in);
      l0_ready  = 1'b1;
      for (int k = 1; k < 4000; k++) begin
         @(posedge clk); #1;
         if (!b2b || k == dn + 2) start = 1'b0;
         if (k == 1) begin
            base_addr = base2;
            if (!b2b) len = 7'd3;
            chk("busy_cycle1", busy, 1);
         end
         l0_ready = !(k >= s0 && k < s0 + sl);
         if (exp_q.size() == 0) break;
      end
      chk("tile_events_pending", exp_q.size(), 0);
      exp_q.delete();
      chk("busy_after_done", busy, 0);
      chk("done_after_done", done, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sram_cen"}, sram_cen, 1);
      chk({tag, "_sram_addr"}, sram_addr, 0);
      chk({tag, "_l0_wr"}, l0_wr, 0);
      chk({tag, "_l0_rd"}, l0_rd, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      reset     = 1'b1;
      start     = 1'b0;
      l0_ready  = 1'b1;
      base_addr = '0;
      len       = '0;
      #1;
      chk_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;

      // Start in the first cycle after reset release; plain 4-vector tile.
      run_tile(11'h010, 4, 0, 0, 1'b0, 11'h3AB);
      // l0_ready low in cycles 2-3.
      run_tile(11'h010, 4, 2, 2, 1'b0, 11'h155);
      // Address wrap.
      run_tile(11'h7FE, 4, 0, 0, 1'b0, 11'h000);
      // Empty tile.
      run_tile(11'h055, 0, 0, 0, 1'b0, 11'h123);
      // Oversized length saturates at DEPTH, with a stall mixed in.
      run_tile(11'h040, 70, 5, 3, 1'b0, 11'h6A0);

      // Reset asserted in cycle 3 of a len=8 tile.
      c0 = cyc;
      push_ev(c0 + 1, K_RD, 11'h030);
      push_ev(c0 + 2, K_RD, 11'h031);
      push_ev(c0 + 2, K_WR, '0);
      start     = 1'b1;
      base_addr = 11'h030;
      len       = 7'd8;
      l0_ready  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk_reset_outputs("midtile_reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midtile_events_pending", exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      run_tile(11'h030, 3, 0, 0, 1'b0, 11'h2C0);

      // Two full-depth tiles with start held high through DONE.
      run_tile(11'h200, 64, 0, 0, 1'b1, 11'h100);

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
